alu_cmd_issuer: RTL
===================

Name: alu_cmd_issuer

Overview:
Initiator-side companion to the team's 4-bit combinational ALU (3-bit opcode, two 4-bit operands, 8-bit result). It accepts operation commands over a valid/ready interface and drives the ALU select and operand inputs. It waits a configurable latency, captures the ALU result and queues it in a small in-order response FIFO. Divide-by-zero is trapped locally. Sits between a command source (bench, microsequencer) and the ALU datapath.

Parameters:
ALU_LAT, 0, cycles the ALU needs after its inputs change before alu_out is valid (0 = purely combinational)
RSP_DEPTH, 4, response FIFO entries; power of 2, at least 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted on a clk edge where cmd_valid&&cmd_ready
cmd_op  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 xor, 110 or, 111 shl
cmd_a  input  4  operand a
cmd_b  input  4  operand b
alu_s  output  3  ALU select, registered
alu_a  output  4  ALU operand a, registered
alu_b  output  4  ALU operand b, registered
alu_out  input  8  ALU result
rsp_valid  output  1  FIFO non-empty
rsp_ready  input  1  consumer takes head entry
rsp_data  output  8  head result
rsp_op  output  3  head opcode
rsp_err  output  1  head entry was divide-by-zero
busy  output  1  state!=IDLE or rsp_valid
op_count  output  16  completed operations, wraps

Behaviour:
- Reset (synchronous, rst high at an edge): state=IDLE; alu_s/alu_a/alu_b=0; FIFO emptied (rsp_valid=0); op_count=0; latency counter=0. Any in-flight command is dropped. Reset has priority over all other events.
- FSM states:
  - IDLE: cmd_ready=1 iff FIFO count < RSP_DEPTH. On accept: register cmd_op/cmd_a/cmd_b into alu_s/alu_a/alu_b, load cnt=ALU_LAT, and set div0 = (cmd_op==011 && cmd_b==0). Go to WAIT.
  - WAIT: cmd_ready=0. If cnt!=0, decrement cnt. If cnt==0, push one entry on this edge and return to IDLE.
    - Normal entry: {alu_out, alu_s, err=0}.
    - div0 entry: {8'hFF, 3'b011, err=1}; alu_out is ignored.
- Only one command is in flight. Capacity is checked at accept time, so a push never meets a full FIFO.
- Timing: accept at edge N, push at edge N+1+ALU_LAT. rsp_valid is high from after that edge. Next accept is possible at edge N+2+ALU_LAT at the earliest, so peak throughput is 1 op per ALU_LAT+2 cycles.
- alu_s/alu_a/alu_b change only on an accept edge. They hold their value through WAIT and while idle.
- Response FIFO:
  - rsp_data/rsp_op/rsp_err are read combinationally from the head entry.
  - Pop on rsp_valid&&rsp_ready.
  - Outputs stay stable while rsp_valid&&!rsp_ready.
  - Simultaneous push and pop leaves the count unchanged and preserves order.
  - Pointers wrap modulo RSP_DEPTH.
  - Pop when empty has no effect.
- op_count: +1 on every push, including div0 entries. Wraps 16'hFFFF -> 0.
- Result semantics come from the ALU: 8-bit width, sub is two's complement (3-5 = 8'hFE), shl is truncated to 8 bits (1<<9 = 8'h00). The issuer never modifies alu_out.

Test Plan:
1. ALU_LAT=0, behavioural ALU attached. Issue add a=15 b=9 at edge N -> alu_s=000, alu_a=15, alu_b=9 after N. Push at N+1; rsp_data=8'h18, rsp_op=000, rsp_err=0, op_count=1.
2. div 15/4 then div 15/0 -> first response 8'h03, err=0. Second response 8'hFF, err=1, rsp_op=011. op_count=2.
3. rsp_ready=0, keep cmd_valid=1 and issue sub 3-5, mul 15*15, shl 1<<9, xor 10^5, or 1|2 -> four accepted, then cmd_ready stays 0. Set rsp_ready=1 -> pops in order 8'hFE, 8'hE1, 8'h00, 8'h0F; fifth command then accepted, result 8'h03.
4. FIFO holding 2 entries, rsp_ready=1 on the same edge a push occurs -> count stays 2; order and data intact.
5. ALU_LAT=3, ALU model delaying alu_out by 3 cycles. Issue and a=12 b=10 at edge N -> push at edge N+4 with 8'h08. alu_a/alu_b stay stable through edges N+1..N+4. cmd_ready=0 until after N+4.
6. rst asserted mid-WAIT with 2 entries queued -> after the reset edge: rsp_valid=0, op_count=0, alu_*=0, state IDLE, cmd_ready=1. The dropped command never appears on rsp.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Command issuer for the 4-bit ALU: accepts one command at a time, drives the ALU,
// waits ALU_LAT cycles, and queues the result (or a divide-by-zero trap) in an in-order FIFO.
module alu_cmd_issuer #(
    parameter int ALU_LAT   = 0,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    output logic [2:0]  alu_s,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [7:0]  alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_L     = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [PTR_W:0]   DEPTH_L   = (PTR_W + 1)'(RSP_DEPTH);
    localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FILL_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [2:0]       OP_DIV    = 3'b011;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div0;
    logic [2:0]       r_alu_s;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [7:0]       w_push_data;
    logic [2:0]       w_push_op;
    logic             w_push_err;
    logic [7:0]       r_mem_data [RSP_DEPTH];
    logic [2:0]       r_mem_op   [RSP_DEPTH];
    logic             r_mem_err  [RSP_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_fill;
    logic [15:0]      r_op_count;
    logic             w_rsp_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake and push decode; capacity is checked only at accept time
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = (r_fill < DEPTH_L);
                if (cmd_valid && w_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_accept    = 1'b0;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_ZERO) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_push      = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ALU drive registers, latency counter and divide-by-zero flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_s <= 3'b000;
            r_alu_a <= 4'h0;
            r_alu_b <= 4'h0;
            r_cnt   <= CNT_ZERO;
            r_div0  <= 1'b0;
        end else if (w_accept) begin
            r_alu_s <= cmd_op;
            r_alu_a <= cmd_a;
            r_alu_b <= cmd_b;
            r_cnt   <= LAT_L;
            r_div0  <= (cmd_op == OP_DIV) && (cmd_b == 4'h0);
        end else if ((r_state == S_WAIT) && (r_cnt != CNT_ZERO)) begin
            r_cnt   <= r_cnt - CNT_ONE;
        end
    end

    // A trapped divide replaces whatever the ALU produced with a fixed marker entry
    always_comb begin
        w_push_err = r_div0;
        if (r_div0) begin
            w_push_data = 8'hFF;
            w_push_op   = OP_DIV;
        end else begin
            w_push_data = alu_out;
            w_push_op   = r_alu_s;
        end
    end

    assign w_rsp_valid = (r_fill != FILL_ZERO);
    assign w_pop       = w_rsp_valid && rsp_ready;

    // Response storage; contents need no reset since fill level guards reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_op[r_wr_ptr]   <= w_push_op;
            r_mem_err[r_wr_ptr]  <= w_push_err;
        end
    end

    // FIFO pointers, fill level and completed-operation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= PTR_ZERO;
            r_rd_ptr   <= PTR_ZERO;
            r_fill     <= FILL_ZERO;
            r_op_count <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                r_op_count <= r_op_count + 16'h0001;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FILL_ONE;
                2'b01:   r_fill <= r_fill - FILL_ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign alu_s     = r_alu_s;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = w_rsp_valid;
    assign rsp_data  = r_mem_data[r_rd_ptr];
    assign rsp_op    = r_mem_op[r_rd_ptr];
    assign rsp_err   = r_mem_err[r_rd_ptr];
    assign busy      = (r_state != S_IDLE) || w_rsp_valid;
    assign op_count  = r_op_count;

endmodule
